pc_seq: RTL

- Parametrised program-sequencing unit for the next-generation monocycle CPU.
- Replaces the fixed 10-bit PC, fixed return stack and separate zero-guard flip-flop with one block, configurable in PC width and stack depth.
- Adds a vectored single-level interrupt with automatic save/restore of PC and Z, sticky stack error flags, and a stack-depth readout.
- Sits between the control unit (decoded strobes) and the program memory (drives its address).

---
 rtl/pc_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// Program-sequencing unit: parametrised PC, shared call/interrupt return
// stack of {z, pc} entries, zero flag, sticky stack error flags and a
// single-level vectored interrupt with automatic PC/Z save and restore.
module pc_seq #(
  parameter int                PC_W        = 10,
  parameter int                STACK_DEPTH = 16,
  parameter logic [PC_W-1:0]   INT_VEC     = PC_W'('h3F0),
  parameter int                DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_inc,
  input  logic [PC_W-1:0]    jmp_addr,
  input  logic               call,
  input  logic               ret,
  input  logic               reti,
  input  logic               z_in,
  input  logic               wez,
  input  logic               irq,
  input  logic               ie,
  input  logic               clr_err,
  output logic [PC_W-1:0]    pc,
  output logic               z,
  output logic               overflow,
  output logic               underflow,
  output logic               in_isr,
  output logic [DEPTH_W-1:0] depth
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0]    r_pc;
  logic               r_z;
  logic               r_ovf;
  logic               r_unf;
  logic               r_in_isr;
  logic [DEPTH_W-1:0] r_depth;
  logic [PC_W:0]      r_stack [STACK_DEPTH];

  logic [PC_W-1:0]    w_seq;
  logic [PC_W-1:0]    w_tgt;
  logic               w_z_next;
  logic               w_full;
  logic               w_empty;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [PC_W:0]      w_top;

  logic [PC_W-1:0]    w_pc_nxt;
  logic               w_z_nxt;
  logic               w_isr_nxt;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic               w_push;
  logic [PC_W:0]      w_push_data;
  logic               w_set_ovf;
  logic               w_set_unf;

  assign w_seq    = r_pc + 1'b1;
  assign w_tgt    = s_inc ? w_seq : jmp_addr;
  assign w_z_next = wez ? z_in : r_z;
  assign w_full   = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign w_empty  = (r_depth == '0);
  // Index truncation only wraps in states where the index is not used
  // (write when full, read when empty).
  assign w_wr_idx = IDX_W'(r_depth);
  assign w_rd_idx = IDX_W'(r_depth - 1'b1);
  assign w_top    = r_stack[w_rd_idx];

  // Prioritised next-state selection: reti > ret > call > irq > sequence/jump
  always_comb begin
    w_pc_nxt    = w_tgt;
    w_z_nxt     = w_z_next;
    w_isr_nxt   = r_in_isr;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_push_data = '0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    if (reti) begin
      if (!w_empty) begin
        w_pc_nxt    = w_top[PC_W-1:0];
        w_z_nxt     = w_top[PC_W];
        w_isr_nxt   = 1'b0;
        w_depth_nxt = r_depth - 1'b1;
      end else begin
        w_pc_nxt  = w_seq;
        w_set_unf = 1'b1;
      end
    end else if (ret) begin
      if (!w_empty) begin
        w_pc_nxt    = w_top[PC_W-1:0];
        w_depth_nxt = r_depth - 1'b1;
      end else begin
        w_pc_nxt  = w_seq;
        w_set_unf = 1'b1;
      end
    end else if (call) begin
      if (!w_full) begin
        w_push      = 1'b1;
        w_push_data = {w_z_next, w_seq};
        w_pc_nxt    = jmp_addr;
        w_depth_nxt = r_depth + 1'b1;
      end else begin
        w_pc_nxt  = w_seq;
        w_set_ovf = 1'b1;
      end
    end else if (irq && ie && !r_in_isr && !w_full) begin
      w_push      = 1'b1;
      w_push_data = {w_z_next, w_tgt};
      w_pc_nxt    = INT_VEC;
      w_isr_nxt   = 1'b1;
      w_depth_nxt = r_depth + 1'b1;
    end
  end

  // Architectural state with synchronous reset; set of a sticky flag wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_z      <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_in_isr <= 1'b0;
      r_depth  <= '0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_z      <= w_z_nxt;
      r_ovf    <= w_set_ovf | (r_ovf & ~clr_err);
      r_unf    <= w_set_unf | (r_unf & ~clr_err);
      r_in_isr <= w_isr_nxt;
      r_depth  <= w_depth_nxt;
    end
  end

  // Stack storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_stack[w_wr_idx] <= w_push_data;
    end
  end

  assign pc        = r_pc;
  assign z         = r_z;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign in_isr    = r_in_isr;
  assign depth     = r_depth;

endmodule
